// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with per-port registered response slots and saturating grant counters.
module alu_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_op1,
   input  logic [DATA_WIDTH-1:0] req0_op2,
   input  logic [3:0]            req0_ctrl,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_op1,
   input  logic [DATA_WIDTH-1:0] req1_op2,
   input  logic [3:0]            req1_ctrl,
   output logic [DATA_WIDTH-1:0] alu_op1,
   output logic [DATA_WIDTH-1:0] alu_op2,
   output logic [3:0]            alu_ctrl,
   input  logic [DATA_WIDTH-1:0] alu_out,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [DATA_WIDTH-1:0] rsp0_data,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp1_data,
   output logic [CNT_WIDTH-1:0]  grant_cnt0,
   output logic [CNT_WIDTH-1:0]  grant_cnt1
);

   localparam logic [3:0]           CTRL_IDLE = 4'b1111;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic prio;
   logic elig0;
   logic elig1;
   logic gnt0;
   logic gnt1;

   // A port may issue when its response slot is empty or draining this cycle.
   always_comb begin
      elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
      elig1 = req1_valid && (!rsp1_valid || rsp1_ready);
      gnt0  = rst_n && elig0 && (!elig1 || !prio);
      gnt1  = rst_n && elig1 && (!elig0 ||  prio);
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Idle drive selects the ALU default case so it outputs zero.
   always_comb begin
      alu_op1  = '0;
      alu_op2  = '0;
      alu_ctrl = CTRL_IDLE;
      if (gnt0) begin
         alu_op1  = req0_op1;
         alu_op2  = req0_op2;
         alu_ctrl = req0_ctrl;
      end else if (gnt1) begin
         alu_op1  = req1_op1;
         alu_op2  = req1_op2;
         alu_ctrl = req1_ctrl;
      end
   end

   // Priority passes to the other port after each grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (gnt0) begin
         prio <= 1'b1;
      end else if (gnt1) begin
         prio <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
      end else if (gnt0) begin
         rsp0_valid <= 1'b1;
         rsp0_data  <= alu_out;
      end else if (rsp0_ready) begin
         rsp0_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
      end else if (gnt1) begin
         rsp1_valid <= 1'b1;
         rsp1_data  <= alu_out;
      end else if (rsp1_ready) begin
         rsp1_valid <= 1'b0;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (gnt0 && (grant_cnt0 != CNT_MAX)) begin
            grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
         end
         if (gnt1 && (grant_cnt1 != CNT_MAX)) begin
            grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, for example the execute stage and an address-generation/CSR helper. Each cycle it grants at most one requester with round-robin fairness and drives the winner's operands and opcode onto the ALU. It captures `ALUout` into a per-requester response register with valid/ready backpressure, and keeps saturating per-port grant counters for performance monitoring.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: operand and result width.
- `CNT_WIDTH`, default 16: width of each grant counter.

**Ports**
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid`, `req1_valid`  in  1  request present on port 0 / 1.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle. Combinational, equal to the port's grant.
- `req0_op1`, `req0_op2`, `req1_op1`, `req1_op2`  in  DATA_WIDTH  operands.
- `req0_ctrl`, `req1_ctrl`  in  4  ALU opcode (0000 ADD … 1010 pass op2).
- `alu_op1`, `alu_op2`  out  DATA_WIDTH  to shared ALU `ALUop1` / `ALUop2`.
- `alu_ctrl`  out  4  to shared ALU `ALUctrl`.
- `alu_out`  in  DATA_WIDTH  from shared ALU `ALUout`.
- `rsp0_valid`, `rsp1_valid`  out  1  response register full.
- `rsp0_ready`, `rsp1_ready`  in  1  consumer takes the response this cycle.
- `rsp0_data`, `rsp1_data`  out  DATA_WIDTH  registered result.
- `grant_cnt0`, `grant_cnt1`  out  CNT_WIDTH  saturating count of accepted requests per port.

## Operation

**Eligibility and grant**
- Port i is eligible when `reqi_valid && (!rspi_valid || rspi_ready)`.
- Grant rule, one grant per cycle at most:
  - Only one port eligible: grant that port.
  - Both eligible: grant the port named by the priority pointer `prio` (0 or 1).
  - Neither eligible: no grant.
- `prio` update: after a grant to port i, `prio` becomes 1-i. With no grant, `prio` holds.

**ALU drive**
- Combinational mux from the granted port onto `alu_op1`, `alu_op2`, `alu_ctrl`.
- With no grant, drive `alu_op1=0`, `alu_op2=0`, `alu_ctrl=4'b1111`, so the ALU default case outputs 0.
- Opcodes pass through unchecked. Reserved codes (1011–1111) therefore return 0.

**Response register i, on the clock edge**
- Granted: `rspi_data <= alu_out` and `rspi_valid <= 1`. This also applies when the register was full and is being drained in the same cycle (pass-through; `rspi_valid` stays 1).
- Not granted and `rspi_ready`: `rspi_valid <= 0`. `rspi_data` holds its stale value.
- Otherwise: hold.

**Grant counters**
- `grant_cnti` increments on every grant to port i.
- Saturates at all-ones and never wraps.

**Reset**
- `rst_n` low immediately clears `rsp0_valid`, `rsp1_valid`, `rsp0_data`, `rsp1_data`, `grant_cnt0`, `grant_cnt1` to 0 and sets `prio` to 0.
- Any pending response is discarded, including on a mid-operation reset.
- While `rst_n` is low, `req*_ready` = 0 and the ALU drive is the idle value.
- The first grant after reset with both ports eligible goes to port 0.

## Timing

- Latency 1: a request accepted in cycle k (valid && ready) gives `rspi_valid=1` with the result from cycle k+1.
- Aggregate throughput is one operation per cycle. One port with its `rspi_ready` tied high sustains one operation per cycle.
- The `req*_valid` → `req*_ready` path is combinational, as is `req*` → `alu_*` → `alu_out` → `rsp*_data` D-input. The full path through the ALU must close in one cycle.
- A requester must hold `op1`, `op2`, `ctrl` stable while valid and not ready. `ready` never depends on the operand values.
- Reset assertion is asynchronous. Deassertion must be synchronised externally to `clk`.

## Test plan

1. **Reset:** hold `rst_n=0` with both `req*_valid=1` → `req*_ready=0`, `rsp*_valid=0`, `rsp*_data=0`, `grant_cnt*=0`, `alu_ctrl=1111`. Release → first grant goes to port 0.
2. **Single op:** port 0 ADD with op1=5, op2=7, `rsp0_ready=1` → `req0_ready=1` in cycle k, `rsp0_valid=1` and `rsp0_data=12` in k+1, `rsp0_valid=0` in k+2. Also SUB 3−5 → `0xFFFFFFFE`.
3. **Fairness:** both ports valid continuously, port 0 XOR and port 1 OR, both `rsp_ready=1` → grants alternate 0,1,0,1 for 8 cycles. Each `grant_cnt` reaches 4.
4. **Backpressure:** `rsp0_valid=1`, `rsp0_ready=0`, `req0_valid=1` → `req0_ready=0`, `rsp0_data` held. Port 1 is granted every cycle despite `prio=0`.
5. **Drain and accept together:** `rsp0` full with value A, `rsp0_ready=1`, new port 0 request LSL 1<<4 granted → next cycle `rsp0_valid` stays 1 and `rsp0_data=16`.
6. **Mid-operation reset and saturation:** pulse `rst_n` low between clock edges with `rsp1_valid=1` → `rsp1_valid` clears immediately, without waiting for a clock edge. With `CNT_WIDTH=4`, 20 grants to port 1 leave `grant_cnt1=15`.
